// File: rtl/fft_seq_ctrl_if.sv
// Stream handshakes plus RAM, butterfly and twiddle control between the FFT sequencer and its datapath.
// Latency: none, wiring only.
// Backpressure: valid/ready on the input stream (in_ready_o) and on the output stream (out_ready_i).
interface fft_seq_ctrl_if #(
    parameter int LOG2N = 10
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic             out_ready_i;
    logic             out_valid_o;
    logic             out_last_o;
    logic             mem_rd_en_o;
    logic [LOG2N-1:0] mem_addr_a_o;
    logic [LOG2N-1:0] mem_addr_b_o;
    logic             mem_we_a_o;
    logic             mem_we_b_o;
    logic [LOG2N-1:0] mem_wr_addr_a_o;
    logic [LOG2N-1:0] mem_wr_addr_b_o;
    logic             src_sel_o;
    logic             bf_ce_o;
    logic [LOG2N-2:0] twiddle_addr_o;
    logic             conj_o;

    // Sequencer side
    modport master (
        input  in_valid_i, out_ready_i,
        output in_ready_o, out_valid_o, out_last_o,
        output mem_rd_en_o, mem_addr_a_o, mem_addr_b_o,
        output mem_we_a_o, mem_we_b_o, mem_wr_addr_a_o, mem_wr_addr_b_o,
        output src_sel_o, bf_ce_o, twiddle_addr_o, conj_o
    );

    // Datapath / stream side
    modport slave (
        output in_valid_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_last_o,
        input  mem_rd_en_o, mem_addr_a_o, mem_addr_b_o,
        input  mem_we_a_o, mem_we_b_o, mem_wr_addr_a_o, mem_wr_addr_b_o,
        input  src_sel_o, bf_ce_o, twiddle_addr_o, conj_o
    );
endinterface

// File: rtl/fft_seq_ctrl.sv
// In-place radix-2 DIT FFT sequencer: bit-reversed load, log2(n) butterfly stages, natural-order unload.
// Latency: butterfly write-back PIPE = RD_LAT + BF_LAT cycles after its read; each stage takes n/2 + PIPE cycles.
// Backpressure: in_ready_o only during LOAD; an output sample holds until out_ready_i, next read issues after acceptance.
module fft_seq_ctrl #(
    parameter int N        = 1024,
    parameter int LOG2_MIN = 3,
    parameter int RD_LAT   = 1,
    parameter int BF_LAT   = 4,
    parameter int LOG2N    = $clog2(N),
    parameter int PIPE     = RD_LAT + BF_LAT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       inverse_i,
    input  logic [$clog2(LOG2N+1)-1:0] log2n_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(LOG2N)-1:0]   stage_o,
    fft_seq_ctrl_if.master             bus
);
    localparam int LW = $clog2(LOG2N + 1);
    localparam int SW = $clog2(LOG2N);
    localparam int TW = LOG2N - 1;
    localparam int FW = $clog2(PIPE);
    localparam int UW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_FLUSH,
        S_UNLOAD
    } state_t;

    state_t           r_state;
    logic [LW-1:0]    r_l;
    logic             r_inv;
    logic [LOG2N-1:0] r_k;
    logic [LOG2N-1:0] r_b;
    logic [SW-1:0]    r_stage;
    logic [FW-1:0]    r_fl;
    logic [LOG2N-1:0] r_j;
    logic             r_un_rd;
    logic [UW-1:0]    r_un_cnt;
    logic             r_ov;
    logic [PIPE-1:0]  r_pv;
    logic [LOG2N-1:0] r_pa [PIPE];
    logic [LOG2N-1:0] r_pb [PIPE];

    logic [LW-1:0]    w_l;
    logic [LOG2N-1:0] w_nm1;
    logic [LOG2N-1:0] w_hm1;
    logic [LOG2N-1:0] w_h;
    logic [LOG2N-1:0] w_mask;
    logic [LOG2N-1:0] w_addr_a;
    logic [LOG2N-1:0] w_addr_b;
    logic [TW-1:0]    w_pos;
    logic [TW-1:0]    w_tw;
    logic [LOG2N-1:0] w_rev_full;
    logic [LOG2N-1:0] w_load_addr;
    logic             w_issue;
    logic             w_load_acc;
    logic             w_wb;
    logic             w_j_last;
    logic             w_last_bf;
    logic             w_last_stage;

    // Clamp the requested size into the supported range before it is latched
    always_comb begin
        w_l = log2n_i;
        if (log2n_i < LW'(LOG2_MIN)) begin
            w_l = LW'(LOG2_MIN);
        end else if (log2n_i > LW'(LOG2N)) begin
            w_l = LW'(LOG2N);
        end
    end

    // n-1 and n/2-1 from the latched size; all terminal compares use these
    assign w_nm1 = {LOG2N{1'b1}} >> (LW'(LOG2N) - r_l);
    assign w_hm1 = w_nm1 >> 1;

    // Butterfly addressing: insert a zero at bit s of b for the upper leg, set it for the lower leg
    assign w_h      = LOG2N'(1) << r_stage;
    assign w_mask   = w_h - LOG2N'(1);
    assign w_addr_a = ((r_b & ~w_mask) << 1) | (r_b & w_mask);
    assign w_addr_b = w_addr_a | w_h;
    // b < n/2 <= N/2 so the in-group position always fits the twiddle width
    assign w_pos    = TW'(r_b & w_mask);
    assign w_tw     = w_pos << (SW'(TW) - r_stage);

    // Bit-reverse over the full width then shift down so only the low L bits are reversed
    always_comb begin
        w_rev_full = '0;
        for (int i = 0; i < LOG2N; i++) begin
            w_rev_full[i] = r_k[LOG2N-1-i];
        end
    end
    assign w_load_addr = w_rev_full >> (LW'(LOG2N) - r_l);

    assign w_issue      = (r_state == S_COMPUTE);
    assign w_load_acc   = (r_state == S_LOAD) && bus.in_valid_i;
    assign w_wb         = r_pv[PIPE-1];
    assign w_j_last     = (r_j == w_nm1);
    assign w_last_bf    = (r_b == w_hm1);
    assign w_last_stage = (r_stage == SW'(r_l - LW'(1)));

    // Sequencer FSM, job counters and the read-to-write-back address pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_l      <= '0;
            r_inv    <= 1'b0;
            r_k      <= '0;
            r_b      <= '0;
            r_stage  <= '0;
            r_fl     <= '0;
            r_j      <= '0;
            r_un_rd  <= 1'b0;
            r_un_cnt <= '0;
            r_ov     <= 1'b0;
            r_pv     <= '0;
            for (int i = 0; i < PIPE; i++) begin
                r_pa[i] <= '0;
                r_pb[i] <= '0;
            end
        end else begin
            r_pv    <= {r_pv[PIPE-2:0], w_issue};
            r_pa[0] <= w_addr_a;
            r_pb[0] <= w_addr_b;
            for (int i = 1; i < PIPE; i++) begin
                r_pa[i] <= r_pa[i-1];
                r_pb[i] <= r_pb[i-1];
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_l     <= w_l;
                        r_inv   <= inverse_i;
                        r_k     <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid_i) begin
                        if (r_k == w_nm1) begin
                            r_b     <= '0;
                            r_stage <= '0;
                            r_state <= S_COMPUTE;
                        end else begin
                            r_k <= r_k + LOG2N'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (w_last_bf) begin
                        r_b     <= '0;
                        r_fl    <= '0;
                        r_state <= S_FLUSH;
                    end else begin
                        r_b <= r_b + LOG2N'(1);
                    end
                end
                S_FLUSH: begin
                    // Hold off the next stage until every write-back of this one has landed
                    if (r_fl == FW'(PIPE - 1)) begin
                        if (w_last_stage) begin
                            r_j     <= '0;
                            r_un_rd <= 1'b1;
                            r_state <= S_UNLOAD;
                        end else begin
                            r_stage <= r_stage + SW'(1);
                            r_state <= S_COMPUTE;
                        end
                    end else begin
                        r_fl <= r_fl + FW'(1);
                    end
                end
                S_UNLOAD: begin
                    if (r_un_rd) begin
                        r_un_rd <= 1'b0;
                        if (RD_LAT == 1) begin
                            r_ov <= 1'b1;
                        end else begin
                            r_un_cnt <= UW'(1);
                        end
                    end else if (!r_ov) begin
                        if (r_un_cnt == UW'(RD_LAT - 1)) begin
                            r_ov <= 1'b1;
                        end else begin
                            r_un_cnt <= r_un_cnt + UW'(1);
                        end
                    end else if (bus.out_ready_i) begin
                        r_ov <= 1'b0;
                        if (w_j_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_j     <= r_j + LOG2N'(1);
                            r_un_rd <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o      = (r_state == S_LOAD);
    assign bus.out_valid_o     = r_ov;
    assign bus.out_last_o      = r_ov && w_j_last;
    assign bus.mem_rd_en_o     = w_issue || ((r_state == S_UNLOAD) && r_un_rd);
    assign bus.mem_addr_a_o    = w_issue ? w_addr_a :
                                 (((r_state == S_UNLOAD) && r_un_rd) ? r_j : '0);
    assign bus.mem_addr_b_o    = w_issue ? w_addr_b : '0;
    assign bus.mem_we_a_o      = w_load_acc || w_wb;
    assign bus.mem_we_b_o      = w_wb;
    assign bus.mem_wr_addr_a_o = w_wb ? r_pa[PIPE-1] : (w_load_acc ? w_load_addr : '0);
    assign bus.mem_wr_addr_b_o = w_wb ? r_pb[PIPE-1] : '0;
    assign bus.src_sel_o       = w_wb;
    assign bus.bf_ce_o         = (r_state == S_COMPUTE) || (r_state == S_FLUSH);
    assign bus.twiddle_addr_o  = w_issue ? w_tw : '0;
    assign bus.conj_o          = r_inv;
    assign busy_o              = (r_state != S_IDLE);
    assign done_o              = (r_state == S_UNLOAD) && r_ov && bus.out_ready_i && w_j_last;
    assign stage_o             = r_stage;
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl with a behavioural RAM and a tagging butterfly model.
// Latency: expects write-back 5 cycles after each butterfly read and output valid 1 cycle after each unload read.
// Backpressure: drives input gaps, a 10-cycle output stall at j=3 and random out_ready.
module tb_fft_seq_ctrl;
    localparam int N     = 1024;
    localparam int LOG2N = 10;
    localparam int PIPE  = 5;

    typedef struct { int a; int b; int tw; int s; } rd_t;
    typedef struct { int t; int a; int b; } wr_t;
    typedef struct { int data; int last; } out_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       inverse_i;
    logic [3:0] log2n_i;
    logic       busy_o;
    logic       done_o;
    logic [3:0] stage_o;

    fft_seq_ctrl_if #(.LOG2N(LOG2N)) bus ();

    fft_seq_ctrl #(
        .N(N), .LOG2_MIN(3), .RD_LAT(1), .BF_LAT(4)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .inverse_i(inverse_i), .log2n_i(log2n_i),
        .busy_o(busy_o), .done_o(done_o), .stage_o(stage_o), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    rd_t  exp_rd [$];
    wr_t  wq [$];
    int   exp_ld [$];
    int   exp_un [$];
    out_t exp_out [$];
    int   mem [N];
    int   cyc = 0;
    int   ld_k = 0;
    int   out_j = 0;
    int   done_cnt = 0;
    int   bf_cycles = 0;
    int   stall_cnt = 0;
    int   last_rd = 0;
    int   cap = 0;
    bit   prev_ov = 0;
    bit   exp_conj = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int bitrev(input int v, input int l);
        int r = 0;
        for (int i = 0; i < l; i++) r |= ((v >> i) & 1) << (l - 1 - i);
        return r;
    endfunction

    // Monitor: model the RAM, retire scoreboard entries as the DUT acts on them
    always @(negedge clk) begin
        wr_t  w;
        rd_t  r;
        int   a;
        bit   hz;
        cyc++;
        if (!rst) begin
            if (bus.mem_we_a_o && bus.src_sel_o) begin
                check("wb_q_nonempty", wq.size() != 0, 1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    check("wb_latency", cyc - w.t, PIPE);
                    check("wb_addr_a", bus.mem_wr_addr_a_o, w.a);
                    check("wb_addr_b", bus.mem_wr_addr_b_o, w.b);
                    check("wb_we_b", bus.mem_we_b_o, 1);
                    mem[w.a] += 256;
                    mem[w.b] += 256;
                end
            end
            if (bus.mem_we_a_o && !bus.src_sel_o) begin
                check("ld_q_nonempty", exp_ld.size() != 0, 1);
                check("ld_handshake", bus.in_valid_i && bus.in_ready_o, 1);
                if (exp_ld.size() != 0) begin
                    a = exp_ld.pop_front();
                    check("ld_addr", bus.mem_wr_addr_a_o, a);
                    mem[a] = ld_k * 3 + 1;
                    ld_k++;
                end
            end
            if (bus.in_valid_i && bus.in_ready_o && !(bus.mem_we_a_o && !bus.src_sel_o))
                check("ld_we", bus.mem_we_a_o && !bus.src_sel_o, 1);
            if (bus.mem_rd_en_o && bus.bf_ce_o) begin
                hz = 0;
                foreach (wq[i])
                    if (wq[i].a == bus.mem_addr_a_o || wq[i].b == bus.mem_addr_a_o ||
                        wq[i].a == bus.mem_addr_b_o || wq[i].b == bus.mem_addr_b_o) hz = 1;
                check("raw_hazard", hz, 0);
                check("rd_q_nonempty", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) begin
                    r = exp_rd.pop_front();
                    check("rd_addr_a", bus.mem_addr_a_o, r.a);
                    check("rd_addr_b", bus.mem_addr_b_o, r.b);
                    check("twiddle", bus.twiddle_addr_o, r.tw);
                    check("stage", stage_o, r.s);
                end
                wq.push_back('{cyc, int'(bus.mem_addr_a_o), int'(bus.mem_addr_b_o)});
            end
            if (bus.bf_ce_o) begin
                bf_cycles++;
                check("conj", bus.conj_o, exp_conj);
            end
            if (bus.mem_rd_en_o && !bus.bf_ce_o) begin
                check("un_q_nonempty", exp_un.size() != 0, 1);
                if (exp_un.size() != 0) check("un_addr", bus.mem_addr_a_o, exp_un.pop_front());
                cap = mem[bus.mem_addr_a_o];
                last_rd = cyc;
            end
            if (bus.out_valid_o && !prev_ov) check("ov_latency", cyc - last_rd, 1);
            if (bus.out_valid_o) begin
                check("out_q_nonempty", exp_out.size() != 0, 1);
                if (exp_out.size() != 0) begin
                    check("out_data", cap, exp_out[0].data);
                    check("out_last", bus.out_last_o, exp_out[0].last);
                    if (bus.out_ready_i) begin
                        void'(exp_out.pop_front());
                        out_j++;
                    end
                end
                if (!bus.out_ready_i) stall_cnt++;
            end
            if (done_o) begin
                done_cnt++;
                check("done_on_last", bus.out_valid_o && bus.out_ready_i && bus.out_last_o, 1);
            end
            prev_ov = bus.out_valid_o;
        end else begin
            prev_ov = 0;
        end
    end

    task automatic clear_sb();
        exp_rd.delete(); wq.delete(); exp_ld.delete(); exp_un.delete(); exp_out.delete();
        ld_k = 0; out_j = 0; done_cnt = 0; bf_cycles = 0; stall_cnt = 0;
    endtask

    // mode: 0 always ready, 1 stall 10 cycles at j=3, 2 random ready
    task automatic run_job(input int lreq, input bit inv, input bit gaps, input int mode,
                           input bit abort, input bit restart_pulse);
        int leff, n, t, wcnt, h, pos, grp;
        leff = (lreq < 3) ? 3 : ((lreq > LOG2N) ? LOG2N : lreq);
        n = 1 << leff;
        clear_sb();
        exp_conj = inv;
        for (int k = 0; k < n; k++) exp_ld.push_back(bitrev(k, leff));
        for (int s = 0; s < leff; s++) begin
            h = 1 << s;
            for (int b = 0; b < n / 2; b++) begin
                pos = b % h;
                grp = b / h;
                exp_rd.push_back('{grp * 2 * h + pos, grp * 2 * h + pos + h, pos * ((N / 2) >> s), s});
            end
        end
        for (int j = 0; j < n; j++) begin
            exp_un.push_back(j);
            exp_out.push_back('{bitrev(j, leff) * 3 + 1 + leff * 256, int'(j == n - 1)});
        end

        @(posedge clk); #1;
        start_i = 1; inverse_i = inv; log2n_i = 4'(lreq);
        @(posedge clk); #1;
        start_i = 0; inverse_i = ~inv; log2n_i = 4'd5;
        check("busy_start", busy_o, 1);
        check("in_rdy_start", bus.in_ready_o, 1);

        t = 0;
        while (ld_k < n && t < 20000) begin
            bus.in_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            start_i = restart_pulse && (ld_k == 2);
            log2n_i = 4'd4;
            @(posedge clk); #1;
            t++;
        end
        bus.in_valid_i = 0;
        start_i = 0;
        check("load_count", ld_k, n);
        check("in_rdy_drop", bus.in_ready_o, 0);

        if (abort) begin
            t = 0;
            while (bf_cycles < 3 && t < 1000) begin @(posedge clk); #1; t++; end
            check("abort_reached", bf_cycles >= 3, 1);
            rst = 1;
            @(posedge clk); #1;
            check("rst_busy", busy_o, 0);
            check("rst_we_a", bus.mem_we_a_o, 0);
            check("rst_we_b", bus.mem_we_b_o, 0);
            check("rst_out_valid", bus.out_valid_o, 0);
            check("rst_rd_en", bus.mem_rd_en_o, 0);
            check("rst_bf_ce", bus.bf_ce_o, 0);
            clear_sb();
            rst = 0;
            wcnt = 0;
            repeat (8) begin
                @(negedge clk);
                if (bus.mem_we_a_o || bus.mem_we_b_o) wcnt++;
            end
            check("rst_no_writes", wcnt, 0);
            check("rst_idle", busy_o, 0);
            return;
        end

        t = 0;
        while (done_cnt == 0 && t < 20000) begin
            if (mode == 1) bus.out_ready_i = !(out_j == 3 && stall_cnt < 10);
            else if (mode == 2) bus.out_ready_i = ($urandom_range(0, 2) != 0);
            else bus.out_ready_i = 1;
            @(posedge clk); #1;
            t++;
        end
        bus.out_ready_i = 0;
        check("done_seen", done_cnt, 1);
        check("busy_after_done", busy_o, 0);
        repeat (4) @(posedge clk);
        #1;
        check("done_once", done_cnt, 1);
        check("out_count", out_j, n);
        check("job_cycles", bf_cycles, leff * (n / 2 + PIPE));
        check("rd_q_empty", exp_rd.size(), 0);
        check("wb_q_empty", wq.size(), 0);
        check("out_q_empty", exp_out.size(), 0);
        if (mode == 1) check("stall_cycles", stall_cnt, 10);
    endtask

    initial begin
        rst = 1; start_i = 0; inverse_i = 0; log2n_i = 0;
        bus.in_valid_i = 0; bus.out_ready_i = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_in_rdy", bus.in_ready_o, 0);
        check("reset_out_valid", bus.out_valid_o, 0);
        check("reset_we", bus.mem_we_a_o | bus.mem_we_b_o, 0);
        check("reset_rd_en", bus.mem_rd_en_o, 0);
        check("reset_conj", bus.conj_o, 0);
        check("reset_stage", stage_o, 0);
        rst = 0;
        @(posedge clk); #1;

        run_job(3, 0, 0, 0, 1, 0);
        run_job(3, 0, 1, 1, 0, 0);
        run_job(1, 1, 0, 0, 0, 1);
        run_job(4, 0, 1, 2, 0, 0);
        run_job(15, 1, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end
endmodule
